// File: rtl/modport_ram_if.sv
// Write/read port bundle for modport_ram. The master side drives addresses, data and enables.
// The slave side is the RAM. MODPORT_RAM_PARITY_EN adds parity_err.
interface modport_ram_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] wrt_address;
    logic                  write;
    logic [ADDR_WIDTH-1:0] rd_address;
    logic                  read;
    logic [DATA_WIDTH-1:0] data_out;
`ifdef MODPORT_RAM_PARITY_EN
    logic                  parity_err;

    modport master (
        output data_in, wrt_address, write, rd_address, read,
        input  data_out, parity_err
    );
    modport slave (
        input  data_in, wrt_address, write, rd_address, read,
        output data_out, parity_err
    );
`else
    modport master (
        output data_in, wrt_address, write, rd_address, read,
        input  data_out
    );
    modport slave (
        input  data_in, wrt_address, write, rd_address, read,
        output data_out
    );
`endif
endinterface

// File: rtl/modport_ram.sv
// Simple dual-port synchronous RAM with a registered, write-first read port.
// Optional MODPORT_RAM_PARITY_EN stores one even-parity bit per byte and reports parity_err.
module modport_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096   // must equal 2**ADDR_WIDTH
) (
    input logic          clock,
    input logic          reset,
    modport_ram_if.slave bus
);
`ifdef MODPORT_RAM_PARITY_EN
    localparam int PAR_W  = DATA_WIDTH / 8;
    localparam int WORD_W = DATA_WIDTH + PAR_W;

    function automatic logic [PAR_W-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
        logic [PAR_W-1:0] p;
        for (int i = 0; i < PAR_W; i++) p[i] = ^d[i*8 +: 8];
        return p;
    endfunction
`else
    localparam int WORD_W = DATA_WIDTH;
`endif

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic              bypass;

    always_comb begin
`ifdef MODPORT_RAM_PARITY_EN
        wr_word = {byte_parity(bus.data_in), bus.data_in};
`else
        wr_word = bus.data_in;
`endif
        // Same-address collision returns the incoming word (write-first).
        bypass  = bus.write && (bus.wrt_address == bus.rd_address);
        rd_word = bypass ? wr_word : mem[bus.rd_address];
    end

    // Array is deliberately never cleared; reset only blocks updates.
    always_ff @(posedge clock) begin
        if (!reset && bus.write) mem[bus.wrt_address] <= wr_word;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.data_out   <= '0;
`ifdef MODPORT_RAM_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
        end else if (bus.read) begin
            bus.data_out   <= rd_word[DATA_WIDTH-1:0];
`ifdef MODPORT_RAM_PARITY_EN
            bus.parity_err <= rd_word[WORD_W-1:DATA_WIDTH] != byte_parity(rd_word[DATA_WIDTH-1:0]);
`endif
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (!reset) begin
            assert (!$isunknown(bus.write)) else $error("modport_ram: write is X/Z");
            assert (!$isunknown(bus.read))  else $error("modport_ram: read is X/Z");
        end
    end
`endif
endmodule

// File: tb/tb_modport_ram.sv
// Randomized bench for modport_ram against an array-based reference memory.
module tb_modport_ram;
    localparam int DW    = 64;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    modport_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    modport_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [DW-1:0] ref_mem [DEPTH];
    bit            known   [DEPTH];
    logic [DW-1:0] exp_out;
    bit            exp_valid;
    int            checks;
    int            failures;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs at negedge, update the model on the edge, settle 1ns after.
    task automatic cycle(input bit rst, input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit r, input logic [AW-1:0] ra);
        @(negedge clock);
        reset           = rst;
        bus.write       = w;
        bus.wrt_address = wa;
        bus.data_in     = wd;
        bus.read        = r;
        bus.rd_address  = ra;
        @(posedge clock);
        if (rst) begin
            exp_out   = '0;
            exp_valid = 1'b1;
        end else begin
            if (w) begin
                ref_mem[wa] = wd;
                known[wa]   = 1'b1;
            end
            if (r) begin
                exp_valid = known[ra];
                exp_out   = ref_mem[ra];
            end
        end
        #1;
    endtask

    task automatic check_out(input string tag);
        if (exp_valid) chk(tag, bus.data_out, exp_out);
    endtask

    initial begin
        checks = 0; failures = 0;
        exp_out = '0; exp_valid = 1'b1;
        reset = 1'b1;
        bus.write = 1'b0; bus.read = 1'b0;
        bus.data_in = '0; bus.wrt_address = '0; bus.rd_address = '0;

        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("reset_out", bus.data_out, '0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("post_reset_idle", bus.data_out, '0);

        // basic write then read
        cycle(0, 1, 12'h005, 64'h0123_4567_89AB_CDEF, 0, 0);
        cycle(0, 0, 0, 0, 1, 12'h005);
        chk("basic_rd", bus.data_out, 64'h0123_4567_89AB_CDEF);

        // address extremes
        cycle(0, 1, 12'h000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        cycle(0, 1, 12'hFFF, 64'hA5A5_A5A5_5A5A_5A5A, 0, 0);
        cycle(0, 0, 0, 0, 1, 12'h000);
        chk("addr_lo", bus.data_out, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(0, 0, 0, 0, 1, 12'hFFF);
        chk("addr_hi", bus.data_out, 64'hA5A5_A5A5_5A5A_5A5A);

        // same-address collision is write-first
        cycle(0, 1, 12'h0A0, 64'h0, 0, 0);
        cycle(0, 1, 12'h0A0, 64'h1111_2222_3333_4444, 1, 12'h0A0);
        chk("collide_wf", bus.data_out, 64'h1111_2222_3333_4444);

        // hold with read=0 while writing elsewhere
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 12'h200 + 12'(i), {$urandom, $urandom}, 0, 0);
            chk("hold", bus.data_out, 64'h1111_2222_3333_4444);
        end

        // concurrent write/read at different addresses
        cycle(0, 1, 12'h011, 64'h0000_0011_0000_0011, 0, 0);
        cycle(0, 1, 12'h010, 64'h0000_0010_0000_0010, 1, 12'h011);
        chk("indep_rd", bus.data_out, 64'h0000_0011_0000_0011);
        cycle(0, 0, 0, 0, 1, 12'h010);
        chk("indep_wr", bus.data_out, 64'h0000_0010_0000_0010);

        // random traffic over a small window to get frequent collisions
        for (int i = 0; i < 300; i++) begin
            bit            w = 1'($urandom);
            bit            r = 1'($urandom);
            logic [AW-1:0] wa = 12'h300 + 12'($urandom_range(0, 15));
            logic [AW-1:0] ra = 12'h300 + 12'($urandom_range(0, 15));
            cycle(0, w, wa, {$urandom, $urandom}, r, ra);
            check_out("rand");
`ifdef MODPORT_RAM_PARITY_EN
            if (r) chk("rand_par", DW'(bus.parity_err), '0);
`endif
        end

        // async reset mid-cycle, ignored write during reset
        cycle(0, 1, 12'h020, 64'h0000_0000_0000_2020, 0, 0);
        cycle(0, 1, 12'h040, 64'hDEAD_BEEF_0000_0001, 0, 0);
        cycle(0, 0, 0, 0, 1, 12'h040);
        chk("pre_reset", bus.data_out, 64'hDEAD_BEEF_0000_0001);
        #2 reset = 1'b1;
        #1;
        exp_out = '0; exp_valid = 1'b1;
        chk("rst_async", bus.data_out, '0);
        cycle(1, 1, 12'h020, 64'hCAFE, 1, 12'h020);
        chk("rst_ignore_rd", bus.data_out, '0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("rst_hold0", bus.data_out, '0);
        cycle(0, 0, 0, 0, 1, 12'h020);
        chk("rst_ignore_wr", bus.data_out, 64'h0000_0000_0000_2020);

`ifdef MODPORT_RAM_PARITY_EN
        cycle(0, 1, 12'h030, 64'h1234_5678_9ABC_DEF0, 0, 0);
        dut.mem[12'h030][DW] = ~dut.mem[12'h030][DW];
        cycle(0, 0, 0, 0, 1, 12'h030);
        chk("par_err", DW'(bus.parity_err), DW'(1));
        cycle(0, 0, 0, 0, 1, 12'h005);
        chk("par_clean", DW'(bus.parity_err), '0);
        cycle(0, 1, 12'h031, 64'h00FF_0F0F_1234_0001, 1, 12'h031);
        chk("par_bypass", DW'(bus.parity_err), '0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/modport_ram.md
Name: modport_ram

Overview:
- Simple dual-port synchronous RAM, 4096 x 64 bits.
- One independent write port and one independent read port share a single clock.
- Testbench-facing leaf block: write-driver/monitor and read-driver/monitor agents attach to the two ports separately.
- Read data is registered, with one-cycle latency.

Parameters:
- DATA_WIDTH, 64, word width in bits.
- ADDR_WIDTH, 12, address width for both ports.
- DEPTH, 4096, number of words; must equal 2**ADDR_WIDTH.

Ports:
- clock  input  1  system clock; all sampling on posedge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  write data.
- wrt_address  input  ADDR_WIDTH  write address.
- write  input  1  write enable.
- rd_address  input  ADDR_WIDTH  read address.
- read  input  1  read enable.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Clock and reset:
  - One clock domain, named clock.
  - Reset is asynchronous and active-high, named reset.
- Reset:
  - data_out forced to 0 immediately on reset assertion and held at 0 while reset is high.
  - Memory array contents are not cleared; they are undefined until written.
  - write/read sampled at an edge while reset is high are ignored: no array update, data_out stays 0.
- Write:
  - At posedge clock with write=1: mem[wrt_address] <= data_in.
  - write=0: no array change.
  - No handshake; every enabled cycle accepts one write.
- Read:
  - At posedge clock with read=1: data_out <= mem[rd_address].
  - Valid one cycle after the edge where read was sampled.
  - read=0: data_out holds its previous value.
- Simultaneous read and write, same address, same edge: write-first.
  - data_out receives the new data_in, not the old contents.
- Simultaneous read and write, different addresses: fully independent; both complete in the same cycle.
- Addresses are full-range (0..4095); no out-of-range condition and no wrap logic needed.
- X on write/read while reset is low:
  - Treat as 0 in synthesis.
  - Flag with a simulation-only assertion.
- Reset deasserted mid-stream:
  - First enabled edge after deassertion operates normally.
  - data_out stays 0 until the first read.

Optional Feature:
- Macro: MODPORT_RAM_PARITY_EN.
- Defined:
  - Array stores one even-parity bit per data byte (8 extra bits per word), computed from data_in on write.
  - Extra output port parity_err (1 bit, registered alongside data_out).
  - On a read, parity_err=1 if any stored byte parity mismatches the recomputed parity of the read data.
  - Write-first bypass path returns computed parity, so parity_err=0 on bypass.
  - parity_err reset value 0; holds when read=0.
  - A bench-only force hook may corrupt a stored parity bit.
- Not defined:
  - No parity storage and no parity_err port.
  - Behaviour identical to the base description.

Test Plan:
- Reset check: assert reset mid-simulation with data_out previously 64'hDEAD_BEEF_0000_0001 -> data_out==0 asynchronously, before the next clock edge; stays 0 until the first read after deassertion.
- Basic write/read: write 64'h0123_4567_89AB_CDEF to addr 12'h005, next cycle read 12'h005 -> data_out==64'h0123_4567_89AB_CDEF one cycle after the read edge.
- Address boundaries:
  - Write 64'hFFFF_FFFF_FFFF_FFFF to 12'h000 and 64'hA5A5_A5A5_5A5A_5A5A to 12'hFFF.
  - Read both -> exact values, no aliasing between addresses.
- Same-address collision: in one edge, write 64'h1111_2222_3333_4444 to 12'h0A0 (old 64'h0) and read 12'h0A0 -> data_out==64'h1111_2222_3333_4444 (write-first).
- Hold and independence:
  - read=0 for 3 cycles while writing other addresses -> data_out unchanged.
  - Concurrent write to 12'h010 and read of 12'h011 -> read returns 12'h011's prior contents.
- Reset vs write: write=1 with 64'hCAFE to 12'h020 on an edge while reset=1; after release, read 12'h020 -> previously written value, not 64'hCAFE.
  - With MODPORT_RAM_PARITY_EN: corrupt a stored parity bit of 12'h030 -> reading 12'h030 gives parity_err==1; a clean address gives parity_err==0.
